// File: rtl/seg_scan_driver_pkg.sv
// Purpose : shared constants and types for the seven-segment scan driver.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: segment codes {dp,g,f,e,d,c,b,a} active-low, digit count, anode-off pattern.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] seg_t;
    typedef logic [NUM_DIGITS-1:0] an_t;

    // Active-low segment patterns; dp (bit 7) is always 1 (off).
    localparam seg_t SEG_0     = 8'hC0;
    localparam seg_t SEG_1     = 8'hF9;
    localparam seg_t SEG_2     = 8'hA4;
    localparam seg_t SEG_3     = 8'hB0;
    localparam seg_t SEG_4     = 8'h99;
    localparam seg_t SEG_5     = 8'h92;
    localparam seg_t SEG_6     = 8'h82;
    localparam seg_t SEG_7     = 8'hF8;
    localparam seg_t SEG_8     = 8'h80;
    localparam seg_t SEG_9     = 8'h90;
    localparam seg_t SEG_BLANK = 8'hFF;

    localparam an_t AN_OFF = 4'b1111;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Purpose : bundles the digit/blink inputs and the an/seg display outputs.
// Latency : n/a (wiring only).
// Backpressure: none; the display side is free-running.
// Modports: master drives digits/blink and observes an/seg; slave is the driver.
interface seg_scan_driver_if;
    import seg_pkg::*;

    bcd_t            digit0;
    bcd_t            digit1;
    bcd_t            digit2;
    bcd_t            digit3;
    logic            blink_en;
    logic [3:0]      blink_mask;
    an_t             an;
    seg_t            seg;

    modport master (
        output digit0, digit1, digit2, digit3, blink_en, blink_mask,
        input  an, seg
    );

    modport slave (
        input  digit0, digit1, digit2, digit3, blink_en, blink_mask,
        output an, seg
    );
endinterface

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Purpose : BCD digit to active-low seven-segment pattern; 10-15 blank.
// Latency : combinational, zero cycles.
// Backpressure: none.
// Ports   : i_bcd (4-bit digit) -> o_seg ({dp,g,f,e,d,c,b,a}, active-low).
module bcd_to_seg
    import seg_pkg::*;
(
    input  bcd_t i_bcd,
    output seg_t o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Purpose : time-multiplexes four BCD digits onto a common-anode display with per-frame snapshot and blink.
// Latency : an/seg registered; they reflect the post-edge digit index on the same edge idx advances.
// Backpressure: none; free-running scan, inputs are sampled whenever needed.
// Ports   : clk, rst (sync, active-high); io_bus.slave carries digit0..3, blink_en, blink_mask in and an, seg out.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 250
)(
    input  logic               clk,
    input  logic               rst,
    seg_scan_driver_if.slave   io_bus
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]         r_idx;
    bcd_t               r_snap [NUM_DIGITS];
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_blink_phase;
    an_t                r_an;
    seg_t               r_seg;

    logic               w_term;
    logic               w_frame_wrap;
    logic               w_blink_wrap;
    logic [1:0]         w_idx_nxt;
    logic               w_phase_nxt;
    bcd_t               w_digit;
    seg_t               w_seg;
    an_t                w_an_nxt;

    assign w_term       = (r_scan_cnt == SCAN_LAST);
    assign w_idx_nxt    = w_term ? (r_idx + 2'd1) : r_idx;
    assign w_frame_wrap = w_term && (r_idx == 2'd3);
    assign w_blink_wrap = w_frame_wrap && (r_frame_cnt == FRAME_LAST);
    assign w_phase_nxt  = r_blink_phase ^ w_blink_wrap;

    // On the frame-wrap edge the snapshot is being reloaded, so digit 0 of the
    // new frame comes straight from the live input rather than the stale snap.
    always_comb begin
        w_digit = r_snap[w_idx_nxt];
        if (w_frame_wrap) begin
            w_digit = io_bus.digit0;
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Blink uses the post-edge phase so an matches the state it is registered with.
    always_comb begin
        w_an_nxt = ~(an_t'(1) << w_idx_nxt);
        if (io_bus.blink_en && io_bus.blink_mask[w_idx_nxt] && w_phase_nxt) begin
            w_an_nxt = AN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt    <= '0;
            r_idx         <= 2'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_snap[i] <= 4'd0;
            end
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_an          <= 4'b1110;
            r_seg         <= SEG_0;
        end else begin
            r_scan_cnt    <= w_term ? '0 : (r_scan_cnt + SCAN_W'(1));
            r_idx         <= w_idx_nxt;
            r_blink_phase <= w_phase_nxt;
            r_an          <= w_an_nxt;
            r_seg         <= w_seg;
            if (w_frame_wrap) begin
                r_snap[0]   <= io_bus.digit0;
                r_snap[1]   <= io_bus.digit1;
                r_snap[2]   <= io_bus.digit2;
                r_snap[3]   <= io_bus.digit3;
                r_frame_cnt <= w_blink_wrap ? '0 : (r_frame_cnt + FRAME_W'(1));
            end
        end
    end

    assign io_bus.an  = r_an;
    assign io_bus.seg = r_seg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Purpose : directed bench for seg_scan_driver with a cycle-count based reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_seg_scan_driver;

    localparam int SD = 4;
    localparam int BF = 2;

    bit clk;
    logic rst;

    seg_scan_driver_if bus();

    seg_scan_driver #(
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit done    = 0;

    // Reference model: everything follows from t = edges since reset.
    int         m_t     = 0;
    bit         m_valid = 0;
    logic [3:0] m_snap [4];
    logic [3:0] exp_an;
    logic [7:0] exp_seg;

    function automatic logic [7:0] f_dec(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int nt, idx, frm, ph;
        logic [3:0] s [4];
        nt = rst ? 0 : m_t + 1;
        for (int i = 0; i < 4; i++) s[i] = rst ? 4'd0 : m_snap[i];
        if (!rst && (nt % (4 * SD) == 0)) begin
            s[0] = bus.digit0; s[1] = bus.digit1;
            s[2] = bus.digit2; s[3] = bus.digit3;
        end
        idx = (nt / SD) % 4;
        frm = nt / (4 * SD);
        ph  = (frm / BF) % 2;
        m_t <= nt;
        for (int i = 0; i < 4; i++) m_snap[i] <= s[i];
        exp_an  <= (bus.blink_en && bus.blink_mask[idx] && ph == 1) ? 4'b1111 : ~(4'b0001 << idx);
        exp_seg <= f_dec(s[idx]);
        if (rst) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid && !done) begin
            n_total++;
            if (bus.an === exp_an && bus.seg === exp_seg) n_pass++;
            else $display("FAIL model t=%0d an=%b seg=%h required an=%b seg=%h",
                          m_t, bus.an, bus.seg, exp_an, exp_seg);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0d actual=%h required=%h", name, m_t, act, exp);
    endtask

    task automatic wait_t(input int target);
        int g;
        g = 0;
        while (m_t != target && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (m_t != target) begin
            n_total++;
            $display("FAIL wait_t actual=%0d required=%0d", m_t, target);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.digit0 = 4'd1; bus.digit1 = 4'd2; bus.digit2 = 4'd3; bus.digit3 = 4'd4;
        bus.blink_en = 1'b1; bus.blink_mask = 4'b0010;
        repeat (3) @(negedge clk);
        chk("rst_an",  {4'b0, bus.an}, 8'h0E);
        chk("rst_seg", bus.seg, 8'hC0);
        rst = 1'b0;

        wait_t(4);   chk("t4_an", {4'b0, bus.an}, 8'h0D);  chk("t4_seg", bus.seg, 8'hC0);
        wait_t(16);  chk("t16_an", {4'b0, bus.an}, 8'h0E); chk("t16_seg", bus.seg, 8'hF9);
        wait_t(18);  bus.digit2 = 4'd7;
        wait_t(20);  chk("t20_an", {4'b0, bus.an}, 8'h0D); chk("t20_seg", bus.seg, 8'hA4);
        wait_t(24);  chk("t24_an", {4'b0, bus.an}, 8'h0B); chk("tear_seg", bus.seg, 8'hB0);
        wait_t(28);  chk("t28_an", {4'b0, bus.an}, 8'h07); chk("t28_seg", bus.seg, 8'h99);
        wait_t(36);  chk("blink_off_a", {4'b0, bus.an}, 8'h0F);
        wait_t(40);  chk("t40_an", {4'b0, bus.an}, 8'h0B); chk("newd2_seg", bus.seg, 8'hF8);
        wait_t(52);  chk("blink_off_b", {4'b0, bus.an}, 8'h0F);
        wait_t(68);  chk("blink_on", {4'b0, bus.an}, 8'h0D); chk("t68_seg", bus.seg, 8'hA4);
        wait_t(100); chk("blink_off_c", {4'b0, bus.an}, 8'h0F);
        wait_t(101); bus.blink_en = 1'b0;
        wait_t(102); chk("blink_dis", {4'b0, bus.an}, 8'h0D);
        bus.digit3 = 4'd12;
        wait_t(124); chk("blank_an", {4'b0, bus.an}, 8'h07); chk("blank_seg", bus.seg, 8'hFF);

        wait_t(138);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_an", {4'b0, bus.an}, 8'h0E);
        chk("mid_rst_seg", bus.seg, 8'hC0);
        rst = 1'b0;
        wait_t(3);   chk("rs_t3_an", {4'b0, bus.an}, 8'h0E);
        wait_t(4);   chk("rs_t4_an", {4'b0, bus.an}, 8'h0D); chk("rs_t4_seg", bus.seg, 8'hC0);
        wait_t(16);  chk("rs_t16_seg", bus.seg, 8'hF9);
        wait_t(28);  chk("rs_blank", bus.seg, 8'hFF);
        wait_t(40);

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Downstream consumer of the stopwatch digit counters. Takes four 4-bit BCD digit values and drives a common-anode 4-digit seven-segment display by time-multiplexing anodes. Snapshots the digits once per scan frame so the display never tears, and optionally blinks selected digits for adjust mode. All outputs are registered and active-low.

## Interface
- SCAN_DIV, 50000, clk cycles each digit is lit (≥2); 100 MHz → 2 kHz digit rate, 500 Hz frame
- BLINK_FRAMES, 250, complete frames per blink half-period (≥1)

- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- digit0  in  4  rightmost digit value (anode 0)
- digit1  in  4  digit value for anode 1
- digit2  in  4  digit value for anode 2
- digit3  in  4  leftmost digit value (anode 3)
- blink_en  in  1  global blink enable
- blink_mask  in  4  bit i set → digit i participates in blinking
- an  out  4  anode enables, active-low, exactly one or zero low
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low; dp always 1 (off)

## Operation
- scan_cnt counts 0..SCAN_DIV-1, wraps to 0; terminal cycle = scan_cnt==SCAN_DIV-1.
- idx (2 bits) increments mod 4 on each terminal cycle.
- Frame wrap: terminal cycle with idx==3. On that edge snap[3:0] loads digit0..digit3; frame_cnt advances.
- frame_cnt counts 0..BLINK_FRAMES-1; on frame wrap with frame_cnt==BLINK_FRAMES-1 it returns to 0 and blink_phase toggles.
- Decode: 0→0xC0, 1→0xF9, 2→0xA4, 3→0xB0, 4→0x99, 5→0x92, 6→0x82, 7→0xF8, 8→0x80, 9→0x90; 10–15 → 0xFF (blank, anode still driven).
- Anode: an = ~(1<<idx), except forced 4'b1111 when blink_en & blink_mask[idx] & blink_phase.
- blink_phase 0 = visible; blink_en low forces all digits visible regardless of phase; blink_mask/blink_en are sampled combinationally into the registered an every cycle (take effect next edge).
- Reset values: scan_cnt=0, idx=0, snap=all 0, frame_cnt=0, blink_phase=0, an=4'b1110, seg=0xC0.

## Timing
- an/seg registered; they change on the same edge as idx, computed from the next idx.
- On frame-wrap edge, seg for the new digit 0 is decoded from the live digit0 input (bypass of snap), so new data appears on the first digit of the new frame.
- Digit inputs changing mid-frame have no effect until the next frame-wrap edge.
- Each digit lit exactly SCAN_DIV cycles; frame = 4·SCAN_DIV cycles; blink half-period = BLINK_FRAMES frames.
- rst dominates all other activity, including mid-frame and mid-blink; state returns to reset values on the next edge.
- Counter widths: $clog2(SCAN_DIV), $clog2(BLINK_FRAMES) (min 1); no overflow beyond terminal values.

## Structure
- Shared package seg_pkg: segment code constants (SEG_0..SEG_9, SEG_BLANK=8'hFF), NUM_DIGITS=4, AN_OFF=4'b1111.
- Sub-module bcd_to_seg: pure combinational 4-bit → 8-bit decoder, instantiated once on the muxed digit value.
- Top holds scan counter, idx, snapshot, blink counter and output registers.

## Test plan
Use SCAN_DIV=4, BLINK_FRAMES=2.
- Reset: assert rst 3 cycles → an=1110, seg=0xC0; hold 4 cycles after release → an=1101, seg=0xC0 (snap still 0).
- Frame load: digits 1,2,3,4 applied from reset → first frame all 0xC0; at cycle 16 an=1110 seg=0xF9, cycle 20 an=1101 seg=0xA4, 24 an=1011 seg=0xB0, 28 an=0111 seg=0x99.
- Anti-tear: change digit2 from 3 to 7 at cycle 18 → cycle 24 still seg=0xB0; cycle 40 seg=0xF8.
- Blink: blink_en=1, blink_mask=0010 → an for idx 1 is 1101 in frames 0–1, 1111 in frames 2–3, 1101 in frames 4–5; other digits unaffected; blink_en=0 mid-phase → 1101 next edge.
- Blank: digit3=12 → seg=0xFF while an=0111.
- Reset mid-frame: rst at cycle 10 (idx=2) → next edge an=1110, seg=0xC0, scan restarts from count 0.
